// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmit path.
package fifo_uart_pkg;

  // Level the serial line rests at between frames.
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } tx_state_t;

  // Serial frame length in clk cycles (start + 8 data + parity + stop bits).
  function automatic int unsigned frame_len(input int unsigned clks_per_bit,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits);
    return (1 + 8 + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Reusable by a receive stage; restart holds the count at zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  output logic [CNT_W-1:0] baud_cnt,
  output logic             bit_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  // Free-running bit-period counter, wraps at the end of every bit.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      baud_cnt <= '0;
    end else if (baud_cnt == LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign bit_tick = (baud_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains fifo_mem one byte at a time and serializes each byte onto tx.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line high, waiting for enable and a non-empty FIFO
// ST_POP    | fifo_rd strobe for one cycle
// ST_LOAD   | FIFO data now valid: capture byte and its parity
// ST_START  | start bit (line low)
// ST_DATA   | 8 data bits, LSB first
// ST_PARITY | even parity bit (only when PARITY_EN=1)
// ST_STOP   | STOP_BITS stop bits (line high); frame_done in last cycle
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       byte_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // frame_done is registered, so it is scheduled one cycle before the end.
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t         state, state_nxt;
  logic [DATA_W-1:0] shift_q, shift_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic              parity_q;
  logic              restart;
  logic              bit_tick;
  logic [CNT_W-1:0]  baud_cnt;
  logic              last_stop;
  logic              done_pre;

  // Timer idles at zero outside the serial part so START always gets a full bit.
  assign restart = (state == ST_IDLE) || (state == ST_POP) || (state == ST_LOAD);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .baud_cnt(baud_cnt),
    .bit_tick(bit_tick)
  );

  assign last_stop = (bit_cnt == LAST_STOP);
  assign done_pre  = (state == ST_STOP) && last_stop && (baud_cnt == PRE_LAST);

  // Next-state, shift register and bit/stop counter decisions.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt;
    case (state)
      ST_IDLE: begin
        if (enable && !fifo_empty) state_nxt = ST_POP;
      end
      ST_POP: begin
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        shift_nxt   = fifo_data;
        bit_cnt_nxt = '0;
        state_nxt   = ST_START;
      end
      ST_START: begin
        if (bit_tick) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_nxt   = shift_q >> 1;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_tick) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (last_stop) state_nxt = ST_IDLE;
          else           bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State plus registered outputs; tx is derived from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt    <= '0;
      parity_q   <= 1'b0;
      tx         <= IDLE_LEVEL;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      byte_count <= '0;
    end else begin
      state      <= state_nxt;
      shift_q    <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      fifo_rd    <= (state_nxt == ST_POP);
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= done_pre;
      if (state == ST_LOAD) parity_q <= ^fifo_data;
      if (done_pre) byte_count <= byte_count + 16'd1;
      case (state_nxt)
        ST_START:  tx <= ~IDLE_LEVEL;
        ST_DATA:   tx <= shift_nxt[0];
        ST_PARITY: tx <= parity_q;
        default:   tx <= IDLE_LEVEL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: two DUTs (no parity / even parity), each fed by a
// queue-based FIFO model; a line decoder checks every serial cycle.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic [1:0]  fifo_empty;
  logic [7:0]  fifo_data [2];
  logic [1:0]  fifo_rd, tx, busy, frame_done;
  logic [15:0] byte_count [2];

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .fifo_empty(fifo_empty[0]),
    .fifo_data(fifo_data[0]), .fifo_rd(fifo_rd[0]), .tx(tx[0]), .busy(busy[0]),
    .frame_done(frame_done[0]), .byte_count(byte_count[0]));

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .fifo_empty(fifo_empty[1]),
    .fifo_data(fifo_data[1]), .fifo_rd(fifo_rd[1]), .tx(tx[1]), .busy(busy[1]),
    .frame_done(frame_done[1]), .byte_count(byte_count[1]));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model state
  logic [7:0] fq [2][$];
  logic [7:0] sent [2][$];
  logic [7:0] dec_log [2][$];
  logic       par_log [$];
  int         starts0 [$];
  int         pushes [2], rd_cnt [2], fd_cnt [2], exp_cnt [2], off [2];
  logic [1:0] in_frame, cnt_pend, prev_rd, rd_s;
  logic [7:0] xb [2], dec [2];
  logic       par_bit;
  logic       rst_seen = 1'b1;
  logic       mon_on = 1'b0;
  int         cyc = 0;

  function automatic int flen(input int d);
    return (10 + d) * C;
  endfunction

  function automatic logic exp_bit(input int d, input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (d == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic monitor();
    for (int d = 0; d < 2; d++) begin
      if (!rst_seen) begin
        chk($sformatf("rst_tx%0d", d), 32'(tx[d]), 32'd1);
        chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
        chk($sformatf("rst_rd%0d", d), 32'(fifo_rd[d]), 32'd0);
        chk($sformatf("rst_done%0d", d), 32'(frame_done[d]), 32'd0);
        chk($sformatf("rst_count%0d", d), 32'(byte_count[d]), 32'd0);
        in_frame[d] = 1'b0; cnt_pend[d] = 1'b0; prev_rd[d] = 1'b0;
        sent[d].delete();
        exp_cnt[d] = 0;
        continue;
      end
      if (fifo_rd[d]) begin
        rd_cnt[d]++;
        chk($sformatf("rd_when_empty%0d", d), 32'(fifo_empty[d]), 32'd0);
        chk($sformatf("rd_back2back%0d", d), 32'(prev_rd[d]), 32'd0);
      end
      prev_rd[d] = fifo_rd[d];
      if (cnt_pend[d]) begin
        chk($sformatf("byte_count%0d", d), 32'(byte_count[d]), 32'(exp_cnt[d]));
        cnt_pend[d] = 1'b0;
      end
      if (frame_done[d]) fd_cnt[d]++;
      if (!in_frame[d] && tx[d] == 1'b0) begin
        in_frame[d] = 1'b1;
        off[d] = 0;
        if (d == 0) starts0.push_back(cyc);
        chk($sformatf("pop_before_start%0d", d), 32'(sent[d].size() > 0), 32'd1);
        xb[d] = (sent[d].size() > 0) ? sent[d].pop_front() : 8'h00;
      end
      if (in_frame[d]) begin
        chk($sformatf("tx%0d_bit%0d", d, off[d] / C), 32'(tx[d]), 32'(exp_bit(d, xb[d], off[d] / C)));
        chk($sformatf("busy%0d", d), 32'(busy[d]), 32'd1);
        chk($sformatf("frame_done%0d", d), 32'(frame_done[d]), 32'(off[d] == flen(d) - 1));
        if (off[d] % C == C / 2) begin
          if (off[d] / C >= 1 && off[d] / C <= 8) dec[d][off[d] / C - 1] = tx[d];
          if (d == 1 && off[d] / C == 9) par_bit = tx[d];
        end
        if (off[d] == flen(d) - 1) begin
          in_frame[d] = 1'b0;
          exp_cnt[d]++;
          cnt_pend[d] = 1'b1;
          dec_log[d].push_back(dec[d]);
          if (d == 1) par_log.push_back(par_bit);
          chk($sformatf("decoded%0d", d), 32'(dec[d]), 32'(xb[d]));
        end else begin
          off[d]++;
        end
      end else begin
        chk($sformatf("done_idle%0d", d), 32'(frame_done[d]), 32'd0);
      end
    end
  endtask

  // One clock cycle: monitor at negedge, FIFO model update just after posedge.
  task automatic tick();
    @(negedge clk);
    if (mon_on) monitor();
    rd_s = fifo_rd;
    @(posedge clk);
    rst_seen = rst_n;
    cyc++;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rd_s[d] && fq[d].size() > 0) begin
        fifo_data[d] = fq[d].pop_front();
        sent[d].push_back(fifo_data[d]);
      end
      fifo_empty[d] = (fq[d].size() == 0);
    end
  endtask

  task automatic push(input int d, input logic [7:0] b);
    fq[d].push_back(b);
    fifo_empty[d] = 1'b0;
    pushes[d]++;
  endtask

  task automatic wait_quiet(input int d);
    int n = 0;
    int q = 0;
    while (q < 3 && n < 6000) begin
      tick();
      n++;
      if (fq[d].size() == 0 && sent[d].size() == 0 && !in_frame[d] && !busy[d]) q++;
      else q = 0;
    end
    chk($sformatf("quiet_timeout%0d", d), 32'(n >= 6000), 32'd0);
  endtask

  task automatic wait_start(input int d);
    int n = 0;
    while (!in_frame[d] && n < 200) begin
      tick();
      n++;
    end
    chk($sformatf("start_timeout%0d", d), 32'(in_frame[d]), 32'd1);
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int rd0, f0, lim;
    rst_n = 1'b0; en = 2'b00; fifo_empty = 2'b11;
    fifo_data[0] = 8'h00; fifo_data[1] = 8'h00;
    in_frame = '0; cnt_pend = '0; prev_rd = '0; rd_s = '0; par_bit = 1'b0;
    xb[0] = '0; xb[1] = '0; dec[0] = '0; dec[1] = '0;
    for (int d = 0; d < 2; d++) begin
      pushes[d] = 0; rd_cnt[d] = 0; fd_cnt[d] = 0; exp_cnt[d] = 0; off[d] = 0;
    end

    // 1: reset
    tick(); mon_on = 1'b1; tick(); tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("s1_tx%0d", d), 32'(tx[d]), 32'd1);
      chk($sformatf("s1_rd%0d", d), 32'(fifo_rd[d]), 32'd0);
      chk($sformatf("s1_busy%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("s1_done%0d", d), 32'(frame_done[d]), 32'd0);
      chk($sformatf("s1_count%0d", d), 32'(byte_count[d]), 32'd0);
    end
    rst_n = 1'b1; en = 2'b11;
    tick();

    // 2: single byte
    rd0 = rd_cnt[0]; f0 = fd_cnt[0];
    push(0, 8'hA5);
    wait_quiet(0);
    chk("s2_rd_pulses", 32'(rd_cnt[0] - rd0), 32'd1);
    chk("s2_done_pulses", 32'(fd_cnt[0] - f0), 32'd1);
    chk("s2_count", 32'(byte_count[0]), 32'd1);
    chk("s2_byte", 32'(dec_log[0][$]), 32'hA5);

    // 3: back-to-back
    starts0.delete(); rd0 = rd_cnt[0];
    push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
    wait_quiet(0);
    chk("s3_rd_pulses", 32'(rd_cnt[0] - rd0), 32'd3);
    chk("s3_starts", 32'(starts0.size()), 32'd3);
    if (starts0.size() == 3) begin
      chk("s3_gap1", 32'(starts0[1] - starts0[0]), 32'd43);
      chk("s3_gap2", 32'(starts0[2] - starts0[1]), 32'd43);
    end
    chk("s3_count", 32'(byte_count[0]), 32'd4);

    // 4: parity DUT
    par_log.delete(); f0 = fd_cnt[1];
    push(1, 8'h07); push(1, 8'h03);
    wait_quiet(1);
    chk("s4_frames", 32'(fd_cnt[1] - f0), 32'd2);
    chk("s4_par_cnt", 32'(par_log.size()), 32'd2);
    if (par_log.size() == 2) begin
      chk("s4_par07", 32'(par_log[0]), 32'd1);
      chk("s4_par03", 32'(par_log[1]), 32'd0);
    end
    chk("s4_count", 32'(byte_count[1]), 32'd2);

    // 5: drop enable mid-frame
    rd0 = rd_cnt[0]; f0 = fd_cnt[0];
    push(0, 8'h11); push(0, 8'h22);
    wait_start(0);
    repeat (C + 2) tick();
    en[0] = 1'b0;
    lim = 0;
    while (fd_cnt[0] == f0 && lim < 200) begin tick(); lim++; end
    chk("s5_first_done", 32'(fd_cnt[0] - f0), 32'd1);
    repeat (20) begin
      tick();
      chk("s5_idle_busy", 32'(busy[0]), 32'd0);
      chk("s5_idle_tx", 32'(tx[0]), 32'd1);
    end
    chk("s5_one_pop", 32'(rd_cnt[0] - rd0), 32'd1);
    chk("s5_first_byte", 32'(dec_log[0][$]), 32'h11);
    en[0] = 1'b1;
    wait_quiet(0);
    chk("s5_second_pop", 32'(rd_cnt[0] - rd0), 32'd2);
    chk("s5_second_byte", 32'(dec_log[0][$]), 32'h22);

    // 6: reset pulse during data bit 3
    rd0 = rd_cnt[0]; f0 = fd_cnt[0];
    push(0, 8'hFF); push(0, 8'h5A);
    wait_start(0);
    repeat (16) tick();
    rst_n = 1'b0;
    tick();
    chk("s6_tx", 32'(tx[0]), 32'd1);
    chk("s6_busy", 32'(busy[0]), 32'd0);
    chk("s6_count", 32'(byte_count[0]), 32'd0);
    rst_n = 1'b1;
    wait_quiet(0);
    chk("s6_pops", 32'(rd_cnt[0] - rd0), 32'd2);
    chk("s6_frames", 32'(fd_cnt[0] - f0), 32'd1);
    chk("s6_byte", 32'(dec_log[0][$]), 32'h5A);
    chk("s6_count_after", 32'(byte_count[0]), 32'd1);

    // random traffic with enable toggling
    for (int i = 0; i < 800; i++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(23) == 0) push(d, 8'($urandom));
        if ($urandom_range(40) == 0) en[d] = ~en[d];
      end
      tick();
    end
    en = 2'b11;
    wait_quiet(0);
    wait_quiet(1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rnd_pops%0d", d), 32'(rd_cnt[d]), 32'(pushes[d]));
      chk($sformatf("rnd_count%0d", d), 32'(byte_count[d]), 32'(exp_cnt[d]));
      chk($sformatf("rnd_fifo_left%0d", d), 32'(fq[d].size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
